fft_n_rad2_stream: RTL and testbench

- Streaming radix-2 decimation-in-time FFT: serial complex input (one sample per enabled cycle), parallel N-bin output.
- Sits between the OFDM sample source and per-subcarrier processing.
- Twiddle factors come from an external per-stage, per-butterfly table driven by the caller, not generated internally.

---
 rtl/fft_n_rad2_stream.sv | 138 +++++++++++++
 tb/tb_fft_n_rad2_stream.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_n_rad2_stream.sv
// fft_n_rad2_stream: streaming radix-2 DIT FFT. Serial complex samples in, N parallel bins out.
// Latency: out_valid and fft_out update NUM_STAGES+1 edges after the edge capturing sample N-1.
// Backpressure: none. enable gates capture only; the stage pipeline advances every cycle, so
//   back-to-back frames yield one result every N cycles.
// Ports:
//   clk, reset (async active-low), enable (capture data_in this edge)
//   data_in   : packed {r, i}, each DATA_W signed
//   W_R_STAGE / W_I_STAGE : [stage][butterfly] Q2.14 twiddles (16384 = +1.0), held stable by caller
//   fft_out   : [N-1:0] packed {r, i}, natural bin order; holds until next frame
//   out_valid : one-cycle pulse when fft_out carries a new frame
// Optional: define FFT_STAGE_SCALE_EN to halve X/Y in every stage (output = DFT / N).
module fft_n_rad2_stream #(
  parameter int N               = 8,
  parameter int DATA_W          = 16,
  parameter int NUM_STAGES      = $clog2(N),
  parameter int NUM_BUTTERFLIES = N / 2
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            enable,
  input  logic [2*DATA_W-1:0]                             data_in,
  input  logic [NUM_STAGES-1:0][NUM_BUTTERFLIES-1:0][15:0] W_R_STAGE,
  input  logic [NUM_STAGES-1:0][NUM_BUTTERFLIES-1:0][15:0] W_I_STAGE,
  output logic [N-1:0][2*DATA_W-1:0]                      fft_out,
  output logic                                            out_valid
);

  localparam int CW = 2 * DATA_W;   // one complex word {r, i}
  localparam int PW = DATA_W + 18;  // headroom for 16 x DATA_W products and their sum
  localparam int LG = NUM_STAGES;

  typedef logic [CW-1:0] cplx_t;

  function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] k);
    logic [LG-1:0] r;
    r = '0;
    for (int i = 0; i < LG; i++) r[i] = k[LG-1-i];
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] hi, lo;
    hi = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      return hi[DATA_W-1:0];
    else if (v < lo) return lo[DATA_W-1:0];
    else             return v[DATA_W-1:0];
  endfunction

  // Returns {X, Y}: X = A + W*B, Y = A - W*B, product truncated by >>> 14.
  function automatic logic [2*CW-1:0] butterfly(input cplx_t a, input cplx_t b,
                                                input logic signed [15:0] wr,
                                                input logic signed [15:0] wi);
    logic signed [PW-1:0] ar, ai, br, bi, wr_x, wi_x, tr, ti, xr, xi, yr, yi;
    ar   = PW'($signed(a[CW-1:DATA_W]));
    ai   = PW'($signed(a[DATA_W-1:0]));
    br   = PW'($signed(b[CW-1:DATA_W]));
    bi   = PW'($signed(b[DATA_W-1:0]));
    wr_x = PW'(wr);
    wi_x = PW'(wi);
    tr   = (wr_x * br - wi_x * bi) >>> 14;
    ti   = (wr_x * bi + wi_x * br) >>> 14;
    xr   = ar + tr;
    xi   = ai + ti;
    yr   = ar - tr;
    yi   = ai - ti;
`ifdef FFT_STAGE_SCALE_EN
    xr   = xr >>> 1;
    xi   = xi >>> 1;
    yr   = yr >>> 1;
    yi   = yi >>> 1;
`else
`endif
    return {sat(xr), sat(xi), sat(yr), sat(yi)};
  endfunction

  logic [LG-1:0]         cnt_q;
  cplx_t                 buf_q   [N];
  logic                  launch_q;   // sample N-1 was captured on the previous edge
  cplx_t                 stage_q [NUM_STAGES][N];
  cplx_t                 stage_d [NUM_STAGES][N];
  cplx_t                 pin     [NUM_STAGES][N];
  logic [NUM_STAGES-1:0] vld_q;

  always_comb begin
    int          half, top, bot;
    logic [2*CW-1:0] r_v;
    half = 1;
    top  = 0;
    bot  = 0;
    r_v  = '0;
    for (int s = 0; s < NUM_STAGES; s++)
      for (int k = 0; k < N; k++) begin
        stage_d[s][k] = '0;
        pin[s][k]     = '0;
      end
    // Stage 0 reads the bit-reversed input buffer; later stages read their predecessor.
    for (int k = 0; k < N; k++) pin[0][k] = buf_q[k];
    for (int s = 1; s < NUM_STAGES; s++)
      for (int k = 0; k < N; k++) pin[s][k] = stage_q[s-1][k];
    for (int s = 0; s < NUM_STAGES; s++)
      for (int b = 0; b < NUM_BUTTERFLIES; b++) begin
        half = 1 << s;
        top  = (b / half) * (2 * half) + (b % half);
        bot  = top + half;
        r_v  = butterfly(pin[s][top], pin[s][bot], W_R_STAGE[s][b], W_I_STAGE[s][b]);
        stage_d[s][top] = r_v[2*CW-1:CW];
        stage_d[s][bot] = r_v[CW-1:0];
      end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      launch_q  <= 1'b0;
      vld_q     <= '0;
      out_valid <= 1'b0;
      fft_out   <= '0;
      for (int k = 0; k < N; k++) buf_q[k] <= '0;
      for (int s = 0; s < NUM_STAGES; s++)
        for (int k = 0; k < N; k++) stage_q[s][k] <= '0;
    end else begin
      if (enable) begin
        buf_q[bitrev(cnt_q)] <= data_in;
        cnt_q                <= cnt_q + 1'b1;
      end
      launch_q <= enable && (cnt_q == LG'(N - 1));
      // Stage registers run freely; the valid chain marks which contents are a real frame.
      for (int s = 0; s < NUM_STAGES; s++)
        for (int k = 0; k < N; k++) stage_q[s][k] <= stage_d[s][k];
      vld_q     <= {vld_q[NUM_STAGES-2:0], launch_q};
      out_valid <= vld_q[NUM_STAGES-1];
      if (vld_q[NUM_STAGES-1])
        for (int k = 0; k < N; k++) fft_out[k] <= stage_q[NUM_STAGES-1][k];
    end
  end

endmodule

// File: tb/tb_fft_n_rad2_stream.sv
// tb_fft_n_rad2_stream: directed-vector bench for fft_n_rad2_stream (N=8, DATA_W=16).
// Expected bins come from a floating-point DFT of each frame the bench sends, clamped to 16 bits.
// A monitor checks out_valid timing and fft_out (new value or held value) every cycle.
module tb_fft_n_rad2_stream;
  localparam int N   = 8;
  localparam int DW  = 16;
  localparam int NS  = 3;
  localparam int NB  = 4;
  localparam int TOL = 2;
  localparam real PI = 3.14159265358979;

  logic                       clk     = 1'b0;
  logic                       reset   = 1'b1;
  logic                       enable  = 1'b0;
  logic [2*DW-1:0]            data_in = '0;
  logic [NS-1:0][NB-1:0][15:0] w_r;
  logic [NS-1:0][NB-1:0][15:0] w_i;
  logic [N-1:0][2*DW-1:0]     fft_out;
  logic                       out_valid;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  fft_n_rad2_stream #(.N(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .data_in   (data_in),
    .W_R_STAGE (w_r),
    .W_I_STAGE (w_i),
    .fft_out   (fft_out),
    .out_valid (out_valid)
  );

  typedef struct packed {
    int                 due;
    logic [N-1:0][31:0] er;
    logic [N-1:0][31:0] ei;
  } exp_t;

  // Written only by the stimulus process
  exp_t exp_a [64];
  int   n_exp      = 0;
  int   discard_to = 0;
  int   cur_r [N];
  int   cur_i [N];
  int   cur_n      = 0;
  int   last_cap   = 0;
  int   fr [N];
  int   fi [N];
  // Written only by the monitor
  int   rd_idx = 0;
  int   pulses = 0;
  int   hold_r [N];
  int   hold_i [N];

  task automatic check(input bit ok, input string name, input int act, input int req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int rnd_sat(input real v);
    int x;
    if (v >= 0.0) x = $rtoi(v + 0.5);
    else          x = $rtoi(v - 0.5);
    if (x > 32767)  x = 32767;
    if (x < -32768) x = -32768;
    return x;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_frame(input int due);
    exp_t e;
    real  th, sr, si;
    e = '0;
    e.due = due;
    for (int k = 0; k < N; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        th = 2.0 * PI * real'(k * n) / real'(N);
        sr = sr + real'(cur_r[n]) * $cos(th) + real'(cur_i[n]) * $sin(th);
        si = si + real'(cur_i[n]) * $cos(th) - real'(cur_r[n]) * $sin(th);
      end
      e.er[k] = rnd_sat(sr);
      e.ei[k] = rnd_sat(si);
    end
    exp_a[n_exp] = e;
    n_exp++;
  endtask

  task automatic drive(input bit en, input int r, input int i);
    @(negedge clk);
    enable  = en;
    data_in = {r[15:0], i[15:0]};
    if (en) begin
      last_cap     = edge_cnt + 1;
      cur_r[cur_n] = r;
      cur_i[cur_n] = i;
      cur_n++;
      if (cur_n == N) begin
        model_frame(edge_cnt + 1 + NS + 1);
        cur_n = 0;
      end
    end
  endtask

  task automatic send_frame(input int gap);
    for (int n = 0; n < N; n++) begin
      drive(1'b1, fr[n], fi[n]);
      if (n == gap) repeat (3) drive(1'b0, 0, 0);
    end
  endtask

  task automatic chk_bin(input int k, input int er, input int ei, input string nm);
    int r, i;
    r = $signed(fft_out[k][31:16]);
    i = $signed(fft_out[k][15:0]);
    check(iabs(r - er) <= 1, $sformatf("%s_bin%0d_r", nm, k), r, er);
    check(iabs(i - ei) <= 1, $sformatf("%s_bin%0d_i", nm, k), i, ei);
  endtask

  // Waits for the result of the frame just sent; leaves the bench one cycle after the pulse.
  task automatic wait_out(input string nm, output bit seen);
    seen = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #2;
      if (out_valid) seen = 1'b1;
    end
    check(seen, {nm, "_seen"}, int'(seen), 1);
  endtask

  task automatic check_latency_width(input string nm);
    check(edge_cnt - last_cap == NS + 1, {nm, "_latency"}, edge_cnt - last_cap, NS + 1);
  endtask

  task automatic check_width(input string nm);
    @(posedge clk);
    #2;
    check(out_valid == 1'b0, {nm, "_pulse_width"}, int'(out_valid), 0);
  endtask

  // Monitor: out_valid only on due edges, fft_out equal to latest expected frame (or held).
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        for (int k = 0; k < N; k++) begin
          hold_r[k] = 0;
          hold_i[k] = 0;
        end
        check(out_valid == 1'b0, "valid_in_reset", int'(out_valid), 0);
        check(fft_out == '0, "out_zero_in_reset", (fft_out == '0) ? 0 : 1, 0);
      end else begin
        if (rd_idx < discard_to) rd_idx = discard_to;
        while (rd_idx < n_exp && exp_a[rd_idx].due < edge_cnt) begin
          tests++;
          fails++;
          $display("FAIL missing_out_valid: edge %0d, expected pulse at edge %0d",
                   edge_cnt, exp_a[rd_idx].due);
          rd_idx++;
        end
        if (out_valid) begin
          pulses++;
          check(rd_idx < n_exp && exp_a[rd_idx].due == edge_cnt, "out_valid_timing", edge_cnt,
                (rd_idx < n_exp) ? exp_a[rd_idx].due : -1);
          if (rd_idx < n_exp && exp_a[rd_idx].due == edge_cnt) begin
            for (int k = 0; k < N; k++) begin
              hold_r[k] = $signed(exp_a[rd_idx].er[k]);
              hold_i[k] = $signed(exp_a[rd_idx].ei[k]);
            end
            rd_idx++;
          end
        end
        for (int k = 0; k < N; k++) begin
          int r, i;
          r = $signed(fft_out[k][31:16]);
          i = $signed(fft_out[k][15:0]);
          check(iabs(r - hold_r[k]) <= TOL, $sformatf("model_bin%0d_r", k), r, hold_r[k]);
          check(iabs(i - hold_i[k]) <= TOL, $sformatf("model_bin%0d_i", k), i, hold_i[k]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  tw_r2 [NB];
    int  tw_i2 [NB];
    bit  seen;
    int  p0;

    tw_r2 = '{16384, 11585, 0, -11585};
    tw_i2 = '{0, -11585, -16384, -11585};
    w_r = '0;
    w_i = '0;
    for (int b = 0; b < NB; b++) begin
      w_r[0][b] = 16'(16384);
      w_r[1][b] = 16'((b % 2 == 0) ? 16384 : 0);
      w_i[1][b] = 16'((b % 2 == 0) ? 0 : -16384);
      w_r[2][b] = 16'(tw_r2[b]);
      w_i[2][b] = 16'(tw_i2[b]);
    end

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
    check($signed(fft_out[0][31:16]) == 0, "reset_bin0_r", $signed(fft_out[0][31:16]), 0);
    reset = 1'b1;

    // DC: all energy in bin 0
    for (int n = 0; n < N; n++) begin fr[n] = 100; fi[n] = 0; end
    send_frame(-1);
    wait_out("dc", seen);
    if (seen) begin
      check_latency_width("dc");
      chk_bin(0, 800, 0, "dc");
      for (int k = 1; k < N; k++) chk_bin(k, 0, 0, "dc");
      check_width("dc");
    end

    // Impulse: flat spectrum
    for (int n = 0; n < N; n++) begin fr[n] = 0; fi[n] = 0; end
    fr[0] = 1000;
    send_frame(-1);
    wait_out("imp", seen);
    if (seen) begin
      check_latency_width("imp");
      for (int k = 0; k < N; k++) chk_bin(k, 1000, 0, "imp");
      check_width("imp");
    end

    // Alternating sign with a 3-cycle enable gap after 5 samples: only bin 4
    for (int n = 0; n < N; n++) begin fr[n] = (n % 2 == 0) ? 500 : -500; fi[n] = 0; end
    send_frame(4);
    wait_out("gap", seen);
    if (seen) begin
      check_latency_width("gap");
      chk_bin(4, 4000, 0, "gap");
      chk_bin(0, 0, 0, "gap");
      check_width("gap");
    end

    // Imaginary impulse at n=1: exercises the W8^1 / W8^3 twiddles and bin ordering
    for (int n = 0; n < N; n++) begin fr[n] = 0; fi[n] = 0; end
    fi[1] = 300;
    send_frame(-1);
    wait_out("cplx", seen);
    if (seen) begin
      chk_bin(0, 0, 300, "cplx");
      chk_bin(2, 300, 0, "cplx");
      chk_bin(1, 212, 212, "cplx");
    end

    // Mixed directed vector, checked against the DFT model only
    fr = '{123, -456, 789, -1000, 250, 0, -77, 600};
    fi = '{0, 50, -50, 300, -300, 10, 20, -999};
    send_frame(-1);
    wait_out("mixed", seen);

    // Back-to-back: three frames with enable held high
    p0 = pulses;
    for (int n = 0; n < N; n++) begin fr[n] = 100; fi[n] = 0; end
    send_frame(-1);
    for (int n = 0; n < N; n++) begin fr[n] = (n == 0) ? 1000 : 0; fi[n] = 0; end
    send_frame(-1);
    for (int n = 0; n < N; n++) begin fr[n] = (n % 2 == 0) ? 500 : -500; fi[n] = 0; end
    send_frame(-1);
    drive(1'b0, 0, 0);
    repeat (12) @(negedge clk);
    check(pulses - p0 == 3, "b2b_pulse_count", pulses - p0, 3);

    // Reset after 5 samples of a partial frame, then a clean DC frame
    for (int n = 0; n < 5; n++) drive(1'b1, 500, 0);
    @(negedge clk);
    enable     = 1'b0;
    reset      = 1'b0;
    cur_n      = 0;
    discard_to = n_exp;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    p0 = pulses;
    for (int n = 0; n < N; n++) begin fr[n] = 100; fi[n] = 0; end
    send_frame(-1);
    wait_out("rst", seen);
    if (seen) begin
      chk_bin(0, 800, 0, "rst");
      chk_bin(3, 0, 0, "rst");
    end
    repeat (10) @(negedge clk);
    check(pulses - p0 == 1, "rst_pulse_count", pulses - p0, 1);

    // Saturation: full-scale DC clips at +32767 instead of wrapping
    for (int n = 0; n < N; n++) begin fr[n] = 32767; fi[n] = 0; end
    send_frame(-1);
    wait_out("sat", seen);
    if (seen) begin
      check($signed(fft_out[0][31:16]) == 32767, "sat_bin0_r", $signed(fft_out[0][31:16]), 32767);
      chk_bin(1, 0, 0, "sat");
    end

    repeat (10) @(negedge clk);
    check(rd_idx == n_exp, "all_frames_returned", rd_idx, n_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
